dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Multi-cycle data-memory responder: the memory-side endpoint for load/store
//   requests issued by a MIPS core (or its memory stage) over a valid/ready
//   request channel and a valid/ready response channel. It holds a word-addressed
//   RAM, inserts a configurable number of wait states, and flags bad accesses.
//   It replaces the zero-latency data bank for multi-cycle and pipelined cores.
// PARAMETERS
//   DEPTH        1024  number of 32-bit words stored (word index 0..DEPTH-1)
//   WAIT_CYCLES  2     wait states between request acceptance and response (0..15)
// PORTS
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept a request this cycle
//   req_write  in   1   1 = store, 0 = load
//   req_addr   in   32  byte address; must be word aligned
//   req_wdata  in   32  store data
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   requester takes the response this cycle
//   rsp_rdata  out  32  load data; 0 for stores and errors
//   rsp_err    out  1   access was misaligned or out of range
// BEHAVIOUR
//   Reset (rst_n low, async): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0,
//     rsp_err=0, wait counter=0. RAM contents are not cleared.
//   FSM states IDLE, BUSY and RESP:
//     IDLE: req_ready=1. On req_valid&&req_ready, latch write, addr and wdata.
//       Load counter=WAIT_CYCLES and go to BUSY. req_ready drops the next cycle.
//     BUSY: req_ready=0. Decrement the counter each cycle. At the edge where the
//       counter is 0, commit the access and go to RESP. With WAIT_CYCLES=0, BUSY
//       lasts exactly one cycle.
//     RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_ready=1.
//       On rsp_valid&&rsp_ready, go to IDLE. rsp_valid, rsp_rdata and rsp_err
//       clear at that edge.
//   Latency: a request accepted at edge N gives rsp_valid=1 after edge
//     N+WAIT_CYCLES+1. The next request can be accepted no earlier than the cycle
//     after the response handshake. Throughput is therefore at most one access per
//     WAIT_CYCLES+3 cycles with rsp_ready held high.
//   Commit:
//     - index = addr[31:2].
//     - err = (addr[1:0]!=0) || (index >= DEPTH).
//     - Store without err: RAM[index] <= wdata, rsp_rdata=0.
//     - Load without err: rsp_rdata = RAM[index] as it was before this commit.
//     - With err: no RAM write, rsp_rdata=0, rsp_err=1.
//   Inputs are ignored outside IDLE. req_addr, req_wdata and req_write are sampled
//     only on the accept edge, so later changes have no effect.
//   Back-pressure: if rsp_ready stays low, the block stays in RESP indefinitely
//     and req_ready stays 0.
//   Reset mid-operation: a reset in BUSY aborts the access and no store is
//     committed. A reset in RESP drops the response; a store already committed
//     remains in RAM.
//   No combinational path from any input to any output. All outputs are registered.
// TESTING
//   1. Reset, then hold idle: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//   2. Store 0xDEADBEEF to 0x10, then load 0x10 (WAIT_CYCLES=2, rsp_ready=1):
//      - each rsp_valid rises 3 cycles after its accept;
//      - the load returns rdata=0xDEADBEEF, err=0;
//      - the store response has rdata=0.
//   3. Load from 0x13, and store to addr = DEPTH*4:
//      - both give rsp_err=1 and rdata=0;
//      - a follow-up load of word DEPTH-1 shows its prior value, unchanged.
//   4. Hold rsp_ready=0 for 10 cycles after a load response appears:
//      - rsp_valid and rsp_rdata stay stable and req_ready=0 throughout;
//      - raising rsp_ready gives IDLE next cycle.
//   5. Assert rst_n=0 during BUSY of a store of 0x12345678 to 0x20 (old value 0):
//      - outputs return to reset values at once;
//      - a later load of 0x20 returns 0.
//   6. WAIT_CYCLES=0 build, back-to-back loads with req_valid held high:
//      - accepts occur every 3 cycles;
//      - each response appears exactly 1 cycle after its accept.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-addressed data memory behind valid/ready request and response channels.
// Each access waits WAIT_CYCLES wait states; misaligned or out-of-range accesses are flagged.
module dmem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0]     mem [DEPTH];
    logic [29:0]     word_idx;
    logic [IdxW-1:0] ram_idx;
    logic            acc_err;
    logic            commit;
    logic            ram_we;

    assign word_idx = addr_q[31:2];
    assign ram_idx  = word_idx[IdxW-1:0];
    assign acc_err  = (addr_q[1:0] != 2'b00) || (32'(word_idx) >= DEPTH);
    assign ram_we   = commit && write_q && !acc_err;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        commit      = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    write_d     = req_write;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    cnt_d       = 4'(WAIT_CYCLES);
                    req_ready_d = 1'b0;
                    state_d     = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    // Load data is read here, before any write lands on this edge.
                    commit      = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = acc_err;
                    rsp_rdata_d = (!write_q && !acc_err) ? mem[ram_idx] : 32'd0;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                rsp_rdata_d = 32'd0;
                rsp_err_d   = 1'b0;
                req_ready_d = 1'b1;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // RAM is deliberately not reset; an async reset in BUSY clears state_q so no write occurs.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= wdata_q;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid0, req_ready0, req_write0;
    logic [31:0] req_addr0, req_wdata0;
    logic        rsp_valid0, rsp_ready0, rsp_err0;
    logic [31:0] rsp_rdata0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid0),
        .req_ready (req_ready0),
        .req_write (req_write0),
        .req_addr  (req_addr0),
        .req_wdata (req_wdata0),
        .rsp_valid (rsp_valid0),
        .rsp_ready (rsp_ready0),
        .rsp_rdata (rsp_rdata0),
        .rsp_err   (rsp_err0)
    );

    // One full transaction on the WAIT_CYCLES=2 instance; called at posedge+1 while idle.
    // lat counts sampled cycles from the accept edge until rsp_valid is seen.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5555_AAAA;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req_valid  = 1'b0; req_write  = 1'b0; req_addr  = '0; req_wdata  = '0; rsp_ready  = 1'b0;
        req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; rsp_ready0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 ||
                rsp_err !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cyc%0d: got ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
                         i, req_ready, rsp_valid, rsp_rdata, rsp_err);
            end
        end
        checks++;
        if (req_ready0 !== 1'b1 || rsp_valid0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_w0: got ready=%b valid=%b, want 1 0", req_ready0, rsp_valid0);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic        er;
        int          lat;
        txn(1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
        checks++;
        if (lat !== 3) begin
            failures++; $display("FAIL store_latency: got %0d, want 3", lat);
        end
        checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            failures++; $display("FAIL store_rsp: got rdata=%h err=%b, want 0 0", rd, er);
        end
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL after_store_idle: got ready=%b valid=%b, want 1 0", req_ready, rsp_valid);
        end
        txn(1'b0, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if (lat !== 3) begin
            failures++; $display("FAIL load_latency: got %0d, want 3", lat);
        end
        checks++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            failures++; $display("FAIL load_0x10: got rdata=%h err=%b, want deadbeef 0", rd, er);
        end
        txn(1'b1, 32'hFFC, 32'hA5A5_5A5A, rd, er, lat);
        txn(1'b1, 32'h0, 32'h1111_2222, rd, er, lat);
        txn(1'b0, 32'h0, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h1111_2222 || er !== 1'b0) begin
            failures++; $display("FAIL load_0x0: got rdata=%h err=%b, want 11112222 0", rd, er);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          lat;
        txn(1'b0, 32'h13, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'd0 || er !== 1'b1) begin
            failures++; $display("FAIL misaligned_load: got rdata=%h err=%b, want 0 1", rd, er);
        end
        txn(1'b1, DEPTH * 4, 32'hBAD0_BAD0, rd, er, lat);
        checks++;
        if (rd !== 32'd0 || er !== 1'b1 || lat !== 3) begin
            failures++;
            $display("FAIL range_store: got rdata=%h err=%b lat=%0d, want 0 1 3", rd, er, lat);
        end
        txn(1'b1, 32'hFFE, 32'h0BAD_F00D, rd, er, lat);
        checks++;
        if (rd !== 32'd0 || er !== 1'b1) begin
            failures++; $display("FAIL misaligned_store: got rdata=%h err=%b, want 0 1", rd, er);
        end
        txn(1'b0, 32'hFFC, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hA5A5_5A5A || er !== 1'b0) begin
            failures++; $display("FAIL last_word: got rdata=%h err=%b, want a5a55a5a 0", rd, er);
        end
        txn(1'b0, 32'h0, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h1111_2222 || er !== 1'b0) begin
            failures++; $display("FAIL word0_alias: got rdata=%h err=%b, want 11112222 0", rd, er);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; rsp_ready = 1'b0;
        @(posedge clk); #1;
        // A store offered while busy must be ignored.
        req_write = 1'b1; req_wdata = 32'h7777_7777;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 3) begin
            failures++; $display("FAIL bp_latency: got %0d, want 3", n);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0 ||
                req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc%0d: got valid=%b rdata=%h err=%b ready=%b, want 1 deadbeef 0 0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'd0) begin
            failures++;
            $display("FAIL bp_release: got valid=%b ready=%b rdata=%h, want 0 1 0",
                     rsp_valid, req_ready, rsp_rdata);
        end
        txn(1'b0, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL ignored_store: got rdata=%h, want deadbeef", rd);
        end
    endtask

    task automatic test_reset_busy();
        logic [31:0] rd;
        logic        er;
        int          lat;
        txn(1'b1, 32'h20, 32'h0, rd, er, lat);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++; $display("FAIL busy_before_reset: got ready=%b, want 0", req_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 ||
            rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        txn(1'b0, 32'h20, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            failures++; $display("FAIL aborted_store: got rdata=%h err=%b, want 0 0", rd, er);
        end
    endtask

    task automatic test_back_to_back();
        req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 32'h40; req_wdata0 = 32'hCAFE_F00D;
        rsp_ready0 = 1'b1;
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req_valid0 = 1'b1; req_write0 = 1'b0; req_addr0 = 32'h40;
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (req_ready0 !== (k % 3 == 0) || rsp_valid0 !== (k % 3 == 2)) begin
                failures++;
                $display("FAIL b2b_timing k=%0d: got ready=%b valid=%b, want %b %b",
                         k, req_ready0, rsp_valid0, (k % 3 == 0), (k % 3 == 2));
            end
            if (k % 3 == 2) begin
                checks++;
                if (rsp_rdata0 !== 32'hCAFE_F00D || rsp_err0 !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_data k=%0d: got rdata=%h err=%b, want cafef00d 0",
                             k, rsp_rdata0, rsp_err0);
                end
            end
            @(posedge clk); #1;
        end
        req_valid0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_store_load();
        test_errors();
        test_backpressure();
        test_reset_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
